pe_seq_ctrl: RTL and testbench



---
 rtl/pe_seq_ctrl.sv | 262 ++++++++++++++++++++++++++
 tb/tb_pe_seq_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pe_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pe_seq_ctrl
// Brief    : Run-time programmable phase sequencer for a processing element.
//            Walks LOAD -> COMPUTE -> (TRANSMIT -> SHIFT -> COMPUTE)* -> OUTPUT,
//            drives instruction-ROM addressing, data-memory shift strobes and
//            ready/valid forwarding of ALU results.
// Revision : 1.0 - initial release
// ============================================================================
module pe_seq_ctrl #(
  parameter int DATA_WIDTH    = 16,
  parameter int IM_ADDR_WIDTH = 8,
  parameter int CNT_WIDTH     = 8,
  parameter int ITER_WIDTH    = 7,
  parameter int SHIFT_LAT     = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_v,
  input  logic [CNT_WIDTH-1:0]     cfg_load_num,
  input  logic [CNT_WIDTH-1:0]     cfg_inst_num,
  input  logic [CNT_WIDTH-1:0]     cfg_tx_num,
  input  logic [CNT_WIDTH-1:0]     cfg_reg_num,
  input  logic [CNT_WIDTH-1:0]     cfg_alpha_num,
  input  logic [ITER_WIDTH-1:0]    cfg_iter_num,
  input  logic                     din_pe_v,
  input  logic [2*DATA_WIDTH-1:0]  alu_d,
  input  logic                     dout_tx_rdy,
  input  logic                     dout_pe_rdy,
  output logic                     load_v,
  output logic                     cmpt_v,
  output logic                     tx_v,
  output logic                     shift_v,
  output logic                     output_v,
  output logic [IM_ADDR_WIDTH-1:0] inst_addr,
  output logic                     inst_v,
  output logic                     dout_shift_v,
  output logic                     dout_tx_v,
  output logic                     dout_pe_v,
  output logic [2*DATA_WIDTH-1:0]  dout_tx,
  output logic [2*DATA_WIDTH-1:0]  dout_pe,
  output logic [ITER_WIDTH-1:0]    iter_idx,
  output logic                     busy,
  output logic                     done,
  output logic                     cfg_err
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_COMPUTE  = 3'd2,
    S_TRANSMIT = 3'd3,
    S_SHIFT    = 3'd4,
    S_OUTPUT   = 3'd5
  } state_t;

  localparam logic [CNT_WIDTH-1:0]     CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [ITER_WIDTH-1:0]    ITER_ONE = ITER_WIDTH'(1);
  localparam logic [IM_ADDR_WIDTH-1:0] ADDR_ONE = IM_ADDR_WIDTH'(1);

  state_t                   state, state_nxt;
  logic [CNT_WIDTH-1:0]     cnt, cnt_nxt;
  logic [ITER_WIDTH-1:0]    iter_nxt;
  logic [IM_ADDR_WIDTH-1:0] addr_nxt;
  logic                     done_nxt;

  logic [CNT_WIDTH-1:0]     load_num, inst_num, tx_num, reg_num, alpha_num;
  logic [ITER_WIDTH-1:0]    iter_num;
  logic [2*DATA_WIDTH-1:0]  alu_r;

  logic cfg_take, cfg_bad, err_eff, start, stall;

  assign cfg_take = cfg_v && (state == S_IDLE);
  assign cfg_bad  = (cfg_load_num == '0) || (cfg_inst_num == '0) || (cfg_iter_num == '0);
  // A same-cycle config decides whether the start is allowed, since it is
  // the config the run will use.
  assign err_eff  = cfg_take ? cfg_bad : cfg_err;
  assign start    = (state == S_IDLE) && din_pe_v && !err_eff;

  // Phase strobes are pure decodes of the registered state.
  assign load_v   = (state == S_LOAD);
  assign cmpt_v   = (state == S_COMPUTE);
  assign tx_v     = (state == S_TRANSMIT);
  assign shift_v  = (state == S_SHIFT);
  assign output_v = (state == S_OUTPUT);
  assign busy     = (state != S_IDLE);

  assign dout_tx_v = tx_v;
  assign dout_pe_v = output_v;
  assign dout_tx   = tx_v     ? alu_r : '0;
  assign dout_pe   = output_v ? alu_r : '0;
  assign stall     = (tx_v && !dout_tx_rdy) || (output_v && !dout_pe_rdy);

  // Shadow configuration; bad configs leave the previous values in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_num  <= CNT_ONE;
      inst_num  <= CNT_ONE;
      tx_num    <= CNT_ONE;
      reg_num   <= CNT_ONE;
      alpha_num <= CNT_ONE;
      iter_num  <= ITER_ONE;
      cfg_err   <= 1'b0;
    end else if (cfg_take) begin
      if (cfg_bad) begin
        cfg_err <= 1'b1;
      end else begin
        load_num  <= cfg_load_num;
        inst_num  <= cfg_inst_num;
        tx_num    <= cfg_tx_num;
        reg_num   <= cfg_reg_num;
        alpha_num <= cfg_alpha_num;
        iter_num  <= cfg_iter_num;
        cfg_err   <= 1'b0;
      end
    end
  end

  // Sequencer state, phase counter, iteration index and ROM address.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      iter_idx  <= '0;
      inst_addr <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      iter_idx  <= iter_nxt;
      inst_addr <= addr_nxt;
      done      <= done_nxt;
    end
  end

  // Next-state logic: cnt counts cycles (or accepted beats) in the current phase.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    iter_nxt  = iter_idx;
    addr_nxt  = '0;
    done_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_LOAD;
          cnt_nxt   = '0;
          iter_nxt  = '0;
        end
      end
      S_LOAD: begin
        if (cnt == load_num - CNT_ONE) begin
          state_nxt = S_COMPUTE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      S_COMPUTE: begin
        if (cnt == inst_num - CNT_ONE) begin
          cnt_nxt = '0;
          if (iter_idx == iter_num - ITER_ONE) begin
            if (alpha_num == '0) begin
              state_nxt = S_IDLE;
              done_nxt  = 1'b1;
            end else begin
              state_nxt = S_OUTPUT;
            end
          end else if (tx_num != '0) begin
            state_nxt = S_TRANSMIT;
          end else if (reg_num != '0) begin
            state_nxt = S_SHIFT;
          end else begin
            // Back-to-back pass: address restarts from 0.
            state_nxt = S_COMPUTE;
            iter_nxt  = iter_idx + ITER_ONE;
          end
        end else begin
          cnt_nxt  = cnt + CNT_ONE;
          addr_nxt = inst_addr + ADDR_ONE;
        end
      end
      S_TRANSMIT: begin
        if (dout_tx_rdy) begin
          if (cnt == tx_num - CNT_ONE) begin
            cnt_nxt = '0;
            if (reg_num != '0) begin
              state_nxt = S_SHIFT;
            end else begin
              state_nxt = S_COMPUTE;
              iter_nxt  = iter_idx + ITER_ONE;
            end
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
      end
      S_SHIFT: begin
        if (cnt == reg_num - CNT_ONE) begin
          state_nxt = S_COMPUTE;
          cnt_nxt   = '0;
          iter_nxt  = iter_idx + ITER_ONE;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      S_OUTPUT: begin
        if (dout_pe_rdy) begin
          if (cnt == alpha_num - CNT_ONE) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
            done_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // ALU capture register (frozen while a handshake is stalled) and ROM valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_r  <= '0;
      inst_v <= 1'b0;
    end else begin
      if (!stall) begin
        alu_r <= alu_d;
      end
      inst_v <= cmpt_v;
    end
  end

  // Shift-valid delay line matching the data-memory read latency.
  generate
    if (SHIFT_LAT == 0) begin : g_lat0
      assign dout_shift_v = shift_v;
    end else if (SHIFT_LAT == 1) begin : g_lat1
      logic shift_dly;
      // Single-stage delay.
      always_ff @(posedge clk) begin
        if (rst) shift_dly <= 1'b0;
        else     shift_dly <= shift_v;
      end
      assign dout_shift_v = shift_dly;
    end else begin : g_latn
      logic [SHIFT_LAT-1:0] shift_dly;
      // Multi-stage delay, oldest sample in the MSB.
      always_ff @(posedge clk) begin
        if (rst) shift_dly <= '0;
        else     shift_dly <= {shift_dly[SHIFT_LAT-2:0], shift_v};
      end
      assign dout_shift_v = shift_dly[SHIFT_LAT-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pe_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_seq_ctrl
// Brief    : Directed self-checking bench for pe_seq_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pe_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_v;
  logic [7:0]  cfg_load_num, cfg_inst_num, cfg_tx_num, cfg_reg_num, cfg_alpha_num;
  logic [6:0]  cfg_iter_num;
  logic        din_pe_v;
  logic [31:0] alu_d;
  logic        dout_tx_rdy, dout_pe_rdy;
  logic        load_v, cmpt_v, tx_v, shift_v, output_v;
  logic [7:0]  inst_addr;
  logic        inst_v, dout_shift_v, dout_tx_v, dout_pe_v;
  logic [31:0] dout_tx, dout_pe;
  logic [6:0]  iter_idx;
  logic        busy, done, cfg_err;

  int checks   = 0;
  int failures = 0;

  // run statistics gathered by run_mon
  int busy_cyc, tx_beats, addr_err, iter_err, passes, shift_err, shift_cnt;
  int hold_err, data_err, inst_v_err, max_run;
  bit done_seen;

  pe_seq_ctrl #(
    .DATA_WIDTH(16), .IM_ADDR_WIDTH(8), .CNT_WIDTH(8), .ITER_WIDTH(7), .SHIFT_LAT(3)
  ) dut (
    .clk(clk), .rst(rst), .cfg_v(cfg_v),
    .cfg_load_num(cfg_load_num), .cfg_inst_num(cfg_inst_num), .cfg_tx_num(cfg_tx_num),
    .cfg_reg_num(cfg_reg_num), .cfg_alpha_num(cfg_alpha_num), .cfg_iter_num(cfg_iter_num),
    .din_pe_v(din_pe_v), .alu_d(alu_d), .dout_tx_rdy(dout_tx_rdy), .dout_pe_rdy(dout_pe_rdy),
    .load_v(load_v), .cmpt_v(cmpt_v), .tx_v(tx_v), .shift_v(shift_v), .output_v(output_v),
    .inst_addr(inst_addr), .inst_v(inst_v), .dout_shift_v(dout_shift_v),
    .dout_tx_v(dout_tx_v), .dout_pe_v(dout_pe_v), .dout_tx(dout_tx), .dout_pe(dout_pe),
    .iter_idx(iter_idx), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int l, input int i, input int t, input int r,
                         input int a, input int n);
    cfg_v         = 1'b1;
    cfg_load_num  = 8'(l);
    cfg_inst_num  = 8'(i);
    cfg_tx_num    = 8'(t);
    cfg_reg_num   = 8'(r);
    cfg_alpha_num = 8'(a);
    cfg_iter_num  = 7'(n);
  endtask

  // Cycle-by-cycle reference monitor for one run started by the caller.
  task automatic run_mon(input int max_cyc, input int inst_n, input bit stall_en);
    int          pos, run, post, stall_left;
    bit          prev_cmpt, prev_stall, prev_txstall, stall_used;
    logic [31:0] prev_alu, exp_alu, prev_dtx, exp_d;
    logic [2:0]  sh_hist;
    busy_cyc = 0; tx_beats = 0; addr_err = 0; iter_err = 0; passes = 0;
    shift_err = 0; shift_cnt = 0; hold_err = 0; data_err = 0; inst_v_err = 0;
    max_run = 0; done_seen = 0;
    pos = 0; run = 0; post = 0; stall_left = 0; stall_used = 0;
    prev_cmpt = 0; prev_stall = 0; prev_txstall = 0;
    prev_alu = alu_d; exp_alu = alu_d; prev_dtx = '0; sh_hist = '0;
    for (int c = 0; c < max_cyc && post < 4; c++) begin
      tick();
      din_pe_v = 1'b0;
      cfg_v    = 1'b0;
      if (!prev_stall) exp_alu = prev_alu;
      alu_d       = {c[15:0] + 16'h1234, ~c[15:0]};
      dout_tx_rdy = (stall_left == 0);
      if (busy) busy_cyc++;
      if (done) done_seen = 1;
      if (done_seen) post++;
      if (inst_v !== prev_cmpt) inst_v_err++;
      if (cmpt_v) begin
        pos = prev_cmpt ? (pos + 1) % inst_n : 0;
        if (inst_addr !== pos[7:0]) addr_err++;
        if (pos == 0) begin
          if (iter_idx !== passes[6:0]) iter_err++;
          passes++;
        end
        run = prev_cmpt ? run + 1 : 1;
        if (run > max_run) max_run = run;
      end else if (inst_addr !== 8'd0) begin
        addr_err++;
      end
      if (dout_shift_v !== sh_hist[2]) shift_err++;
      sh_hist = {sh_hist[1:0], shift_v};
      if (dout_shift_v) shift_cnt++;
      exp_d = tx_v ? exp_alu : 32'd0;
      if (dout_tx !== exp_d || dout_tx_v !== tx_v) data_err++;
      exp_d = output_v ? exp_alu : 32'd0;
      if (dout_pe !== exp_d || dout_pe_v !== output_v) data_err++;
      if (prev_txstall && (dout_tx !== prev_dtx || !tx_v)) hold_err++;
      if (tx_v && dout_tx_rdy) tx_beats++;
      if (!dout_tx_rdy) stall_left--;
      else if (stall_en && !stall_used && tx_v) begin
        stall_left = 5;
        stall_used = 1;
      end
      prev_txstall = tx_v && !dout_tx_rdy;
      prev_stall   = prev_txstall || (output_v && !dout_pe_rdy);
      prev_alu     = alu_d;
      prev_dtx     = dout_tx;
      prev_cmpt    = cmpt_v;
    end
    dout_tx_rdy = 1'b1;
    check("done_seen", 64'(done_seen), 64'd1);
  endtask

  initial begin
    rst = 1'b1; cfg_v = 1'b0; din_pe_v = 1'b0; alu_d = 32'h0;
    dout_tx_rdy = 1'b1; dout_pe_rdy = 1'b1;
    cfg_load_num = 8'd0; cfg_inst_num = 8'd0; cfg_tx_num = 8'd0;
    cfg_reg_num = 8'd0; cfg_alpha_num = 8'd0; cfg_iter_num = 7'd0;
    tick(); tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_strobes", 64'({load_v, cmpt_v, tx_v, shift_v, output_v}), 64'd0);
    check("rst_misc", 64'({inst_addr, inst_v, iter_idx, done, cfg_err}), 64'd0);
    rst = 1'b0;
    tick();

    // Reset-default run: 1-cycle LOAD, COMPUTE, OUTPUT, then done.
    din_pe_v = 1'b1;
    tick(); din_pe_v = 1'b0;
    check("def_load", 64'({load_v, cmpt_v, output_v, busy}), 64'b1001);
    tick();
    check("def_cmpt", 64'({load_v, cmpt_v, output_v, inst_addr}), 64'({3'b010, 8'd0}));
    tick();
    check("def_out", 64'({load_v, cmpt_v, output_v, dout_pe_v}), 64'b0011);
    tick();
    check("def_done", 64'({done, busy}), 64'b10);
    tick();
    check("def_done_pulse", 64'(done), 64'd0);

    // L=4 I=8 T=2 R=3 A=2 N=3, config and start in the same cycle.
    set_cfg(4, 8, 2, 3, 2, 3);
    din_pe_v = 1'b1;
    run_mon(200, 8, 1'b0);
    check("run_len", 64'(busy_cyc), 64'd40);
    check("run_tx_beats", 64'(tx_beats), 64'd4);
    check("run_passes", 64'(passes), 64'd3);
    check("run_addr", 64'(addr_err), 64'd0);
    check("run_iter", 64'(iter_err), 64'd0);
    check("run_shift_lag", 64'(shift_err), 64'd0);
    check("run_shift_cnt", 64'(shift_cnt), 64'd6);
    check("run_data", 64'(data_err), 64'd0);
    check("run_inst_v", 64'(inst_v_err), 64'd0);

    // Same config, 5-cycle ready drop mid-TRANSMIT.
    din_pe_v = 1'b1;
    run_mon(200, 8, 1'b1);
    check("stall_len", 64'(busy_cyc), 64'd45);
    check("stall_tx_beats", 64'(tx_beats), 64'd4);
    check("stall_hold", 64'(hold_err), 64'd0);
    check("stall_data", 64'(data_err), 64'd0);
    check("stall_addr", 64'(addr_err), 64'd0);

    // T=0 R=0 N=2: back-to-back COMPUTE passes.
    set_cfg(4, 8, 0, 0, 2, 2);
    din_pe_v = 1'b1;
    run_mon(200, 8, 1'b0);
    check("b2b_run", 64'(max_run), 64'd16);
    check("b2b_addr", 64'(addr_err), 64'd0);
    check("b2b_iter", 64'(iter_err), 64'd0);
    check("b2b_len", 64'(busy_cyc), 64'd22);
    check("b2b_no_tx_shift", 64'(tx_beats + shift_cnt), 64'd0);

    // Bad config sets cfg_err and blocks start; a good config clears it.
    set_cfg(4, 0, 2, 3, 2, 3);
    tick(); cfg_v = 1'b0;
    check("cfg_err_set", 64'(cfg_err), 64'd1);
    din_pe_v = 1'b1;
    tick(); din_pe_v = 1'b0;
    check("cfg_err_nostart", 64'({busy, load_v}), 64'd0);
    tick();
    check("cfg_err_idle", 64'(busy), 64'd0);
    set_cfg(4, 8, 2, 3, 2, 3);
    tick(); cfg_v = 1'b0;
    check("cfg_err_clear", 64'(cfg_err), 64'd0);

    // Reset in the second SHIFT cycle, then restart with reset config.
    din_pe_v = 1'b1;
    for (int c = 0; c < 100; c++) begin
      tick();
      din_pe_v = 1'b0;
      if (shift_v) break;
    end
    check("rst_reach_shift", 64'(shift_v), 64'd1);
    tick();
    check("rst_shift2", 64'(shift_v), 64'd1);
    rst = 1'b1;
    tick();
    check("midrst_ctl", 64'({load_v, cmpt_v, tx_v, shift_v, output_v, inst_addr, inst_v,
                             dout_shift_v, dout_tx_v, dout_pe_v, iter_idx, busy, done, cfg_err}),
          64'd0);
    check("midrst_data", {dout_tx, dout_pe}, 64'd0);
    rst = 1'b0;
    din_pe_v = 1'b1;
    run_mon(50, 1, 1'b0);
    check("restart_len", 64'(busy_cyc), 64'd3);
    check("restart_passes", 64'(passes), 64'd1);
    check("restart_data", 64'(data_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
